trip_detect: RTL and testbench
==============================

// Module: trip_detect
// PURPOSE
//  Fault qualifier feeding the PWM kill latch: generates its trip_src input from ADC samples.
//  Compares |phase current| and DC-bus voltage against software thresholds.
//  Requires N consecutive out-of-range samples before it trips.
//  Latches trip_src with a cause code until software clears it.
// PARAMETERS
//  DATA_W     12    sample/threshold width (unsigned)
//  N_CH       3     phase-current channels
//  QUAL_W     4     width of qual_n
//  WD_CYCLES  1000  clk_ctrl cycles without sample_valid before watchdog trip (TRIP_WDOG_EN only)
// PORTS
//  clk_ctrl       in   1             control clock
//  rst_ctrl_n     in   1             async active-low reset
//  det_en         in   1             detector enable (sw)
//  uv_arm         in   1             arm undervoltage check (wired to run_en)
//  sample_valid   in   1             one-cycle strobe: ch_mag/vbus valid
//  ch_mag         in   N_CH*DATA_W   |I| per channel, ch0 in LSBs
//  vbus           in   DATA_W        DC-bus voltage sample
//  thr_oc         in   DATA_W        overcurrent threshold
//  thr_ov         in   DATA_W        overvoltage threshold
//  thr_uv         in   DATA_W        undervoltage threshold
//  qual_n         in   QUAL_W        consecutive samples to qualify (0 treated as 1)
//  sw_clear_fault in   1             clear latched trip (pulse)
//  trip_src       out  1             latched trip to kill latch
//  trip_cause     out  4             one-hot-ish: [0]OC [1]OV [2]UV [3]WDOG
//  trip_ch        out  $clog2(N_CH)  lowest OC channel in trip cycle
//  trip_count     out  8             saturating trips since reset
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; all counters 0.
//  States: IDLE (det_en=0), ARMED, TRIPPED.
//   IDLE->ARMED when det_en=1. ARMED->IDLE when det_en=0.
//   ARMED->TRIPPED on qualification. TRIPPED->ARMED (or IDLE if det_en=0) on sw_clear_fault.
//   det_en=0 does NOT clear TRIPPED; only sw_clear_fault does.
//  Conditions (strict compare): OCk = ch_mag[k] > thr_oc; OV = vbus > thr_ov; UV = uv_arm & (vbus < thr_uv).
//  Qual counters: one per OC channel, plus OV and UV.
//   On sample_valid in ARMED: condition true -> increment, saturate at qual_n; false -> 0.
//   Counters hold when sample_valid=0. Forced to 0 in IDLE/TRIPPED, on clear, and (UV only) when uv_arm=0.
//  Qualify: a counter reaches qual_n on a sample_valid cycle.
//   trip_src=1 the next cycle (1-cycle latency from strobe).
//  trip_cause latches every condition qualifying in that same cycle.
//   Later conditions are not OR'd in while TRIPPED.
//  trip_ch: lowest qualifying OC index. 0 if no OC.
//  trip_count: +1 on each ARMED->TRIPPED; saturates at 255.
//  sw_clear_fault in TRIPPED: next cycle trip_src, trip_cause, trip_ch = 0 and counters = 0.
//   Qualification restarts from scratch.
//   Clear coinciding with a qualifying sample: clear wins; the sample is discarded.
//  sw_clear_fault in ARMED/IDLE: zeroes counters only.
//  thr/qual_n may change at any time; they take effect on the next sample.
//  rst_ctrl_n low mid-trip: immediate return to reset values.
// CONFIGURATION
//  TRIP_WDOG_EN defined: watchdog counter runs in ARMED.
//   Cleared on sample_valid and outside ARMED.
//   Reaching WD_CYCLES -> trip with cause[3].
//  Undefined: no watchdog logic; trip_cause[3] tied 0.
// STRUCTURE
//  trip_pkg: cause bit indices (CAUSE_OC/OV/UV/WDOG), state encoding, 4-bit cause width.
//  Sub-module trip_qual: one saturating consecutive-sample counter.
//   Inputs: clk, rst_n, clr, valid, cond, qual_n. Output: hit.
//   Instantiated N_CH+2 times.
// TESTING
//  1. qual_n=4, thr_oc=2000, ch1=2001 for 3 samples then 1999 -> no trip.
//     Then 4 samples of 2001 -> trip_src=1 one cycle after 4th strobe; cause=0001, trip_ch=1.
//  2. ch_mag=thr_oc exactly for 20 samples -> no trip (strict compare).
//     vbus=thr_ov+1 for qual_n=1 -> immediate trip, cause=0010.
//  3. vbus < thr_uv, uv_arm=0 for 10 samples -> no trip.
//     uv_arm=1 -> trip after qual_n samples, cause=0100.
//  4. ch0 and ch2 OC plus OV qualify on same strobe -> cause=0011, trip_ch=0, trip_count=1.
//     Later UV does not add to cause.
//  5. TRIPPED, det_en dropped -> trip_src stays 1. Clear on qualifying strobe -> trip_src=0, counters 0.
//  6. TRIP_WDOG_EN, ARMED, no strobe for 1000 cycles -> cause=1000.
//     Without macro: no trip after 5000 cycles.

Source files
------------

// File: rtl/trip_pkg.sv
// rtl/trip_pkg.sv - shared cause-bit indices and state encoding for the trip detector
package trip_pkg;

   localparam int CAUSE_W    = 4;
   localparam int CAUSE_OC   = 0;
   localparam int CAUSE_OV   = 1;
   localparam int CAUSE_UV   = 2;
   localparam int CAUSE_WDOG = 3;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_TRIPPED = 2'd2;

   typedef logic [CAUSE_W-1:0] cause_t;

endpackage

// File: rtl/trip_detect_if.sv
// rtl/trip_detect_if.sv - ADC sample stream in, latched trip status out
interface trip_detect_if #(
   parameter int DATA_W = 12,
   parameter int N_CH   = 3,
   parameter int CH_W   = 2
);

   logic                     sample_valid;
   logic [N_CH*DATA_W-1:0]   ch_mag;
   logic [DATA_W-1:0]        vbus;
   logic                     trip_src;
   logic [3:0]               trip_cause;
   logic [CH_W-1:0]          trip_ch;
   logic [7:0]               trip_count;

   modport master (
      output sample_valid, ch_mag, vbus,
      input  trip_src, trip_cause, trip_ch, trip_count
   );

   modport slave (
      input  sample_valid, ch_mag, vbus,
      output trip_src, trip_cause, trip_ch, trip_count
   );

endinterface

// File: rtl/trip_qual.sv
// rtl/trip_qual.sv - saturating consecutive-sample counter; hit when it reaches qual_n on a strobe
module trip_qual #(
   parameter int QUAL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              valid,
   input  logic              cond,
   input  logic [QUAL_W-1:0] qual_n,
   output logic              hit
);

   logic [QUAL_W-1:0] cnt_q, cnt_d;
   logic [QUAL_W-1:0] qn_eff;

   assign qn_eff = (qual_n == '0) ? QUAL_W'(1) : qual_n;

   always_comb begin
      cnt_d = cnt_q;
      hit   = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (valid) begin
         if (cond) begin
            // qual_n may shrink below the running count; clamp rather than wrap
            cnt_d = (cnt_q >= qn_eff) ? qn_eff : cnt_q + QUAL_W'(1);
            hit   = (cnt_d == qn_eff);
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/trip_detect.sv
// rtl/trip_detect.sv - OC/OV/UV fault qualifier with latched trip and cause code
// Optional sample-loss watchdog enabled by defining TRIP_WDOG_EN.
module trip_detect
   import trip_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int N_CH      = 3,
   parameter int QUAL_W    = 4,
   parameter int WD_CYCLES = 1000
) (
   input  logic              clk_ctrl,
   input  logic              rst_ctrl_n,
   input  logic              det_en,
   input  logic              uv_arm,
   input  logic [DATA_W-1:0] thr_oc,
   input  logic [DATA_W-1:0] thr_ov,
   input  logic [DATA_W-1:0] thr_uv,
   input  logic [QUAL_W-1:0] qual_n,
   input  logic              sw_clear_fault,
   trip_detect_if.slave      sbus
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [1:0]      state_q, state_d;
   logic            trip_src_q, trip_src_d;
   cause_t          trip_cause_q, trip_cause_d;
   logic [CH_W-1:0] trip_ch_q, trip_ch_d;
   logic [7:0]      trip_count_q, trip_count_d;

   logic            armed;
   logic            qual_clr;
   logic [N_CH-1:0] oc_hit;
   logic            ov_hit, uv_hit, wd_hit;
   cause_t          new_cause;
   logic [CH_W-1:0] low_ch;

   assign armed    = (state_q == ST_ARMED);
   // A clear on the same strobe as a qualifying sample suppresses the hit
   assign qual_clr = ~armed | sw_clear_fault;

   for (genvar k = 0; k < N_CH; k++) begin : g_oc
      trip_qual #(.QUAL_W(QUAL_W)) u_qual_oc (
         .clk    (clk_ctrl),
         .rst_n  (rst_ctrl_n),
         .clr    (qual_clr),
         .valid  (sbus.sample_valid),
         .cond   (sbus.ch_mag[k*DATA_W +: DATA_W] > thr_oc),
         .qual_n (qual_n),
         .hit    (oc_hit[k])
      );
   end

   trip_qual #(.QUAL_W(QUAL_W)) u_qual_ov (
      .clk    (clk_ctrl),
      .rst_n  (rst_ctrl_n),
      .clr    (qual_clr),
      .valid  (sbus.sample_valid),
      .cond   (sbus.vbus > thr_ov),
      .qual_n (qual_n),
      .hit    (ov_hit)
   );

   trip_qual #(.QUAL_W(QUAL_W)) u_qual_uv (
      .clk    (clk_ctrl),
      .rst_n  (rst_ctrl_n),
      .clr    (qual_clr | ~uv_arm),
      .valid  (sbus.sample_valid),
      .cond   (uv_arm & (sbus.vbus < thr_uv)),
      .qual_n (qual_n),
      .hit    (uv_hit)
   );

`ifdef TRIP_WDOG_EN
   localparam int WD_W = $clog2(WD_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      wd_hit   = 1'b0;
      if (!armed || sbus.sample_valid || sw_clear_fault) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q == WD_W'(WD_CYCLES - 1)) begin
         wd_hit   = 1'b1;
         wd_cnt_d = '0;
      end else begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk_ctrl or negedge rst_ctrl_n) begin
      if (!rst_ctrl_n) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      new_cause             = '0;
      new_cause[CAUSE_OC]   = |oc_hit;
      new_cause[CAUSE_OV]   = ov_hit;
      new_cause[CAUSE_UV]   = uv_hit;
      new_cause[CAUSE_WDOG] = wd_hit;
   end

   always_comb begin
      low_ch = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (oc_hit[k]) begin
            low_ch = CH_W'(k);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      trip_src_d   = trip_src_q;
      trip_cause_d = trip_cause_q;
      trip_ch_d    = trip_ch_q;
      trip_count_d = trip_count_q;
      case (state_q)
         ST_IDLE: begin
            if (det_en) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // A qualifying fault takes priority over a simultaneous disable
            if (new_cause != '0) begin
               state_d      = ST_TRIPPED;
               trip_src_d   = 1'b1;
               trip_cause_d = new_cause;
               trip_ch_d    = low_ch;
               if (trip_count_q != 8'hFF) begin
                  trip_count_d = trip_count_q + 8'd1;
               end
            end else if (!det_en) begin
               state_d = ST_IDLE;
            end
         end
         ST_TRIPPED: begin
            if (sw_clear_fault) begin
               state_d      = det_en ? ST_ARMED : ST_IDLE;
               trip_src_d   = 1'b0;
               trip_cause_d = '0;
               trip_ch_d    = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_ctrl or negedge rst_ctrl_n) begin
      if (!rst_ctrl_n) begin
         state_q      <= ST_IDLE;
         trip_src_q   <= 1'b0;
         trip_cause_q <= '0;
         trip_ch_q    <= '0;
         trip_count_q <= '0;
      end else begin
         state_q      <= state_d;
         trip_src_q   <= trip_src_d;
         trip_cause_q <= trip_cause_d;
         trip_ch_q    <= trip_ch_d;
         trip_count_q <= trip_count_d;
      end
   end

   assign sbus.trip_src   = trip_src_q;
   assign sbus.trip_cause = trip_cause_q;
   assign sbus.trip_ch    = trip_ch_q;
   assign sbus.trip_count = trip_count_q;

endmodule

// File: tb/tb_trip_detect.sv
// tb/tb_trip_detect.sv - vector table plus hand sequences for trip_detect
module tb_trip_detect;

   localparam logic [11:0] THR_OC = 12'd2000;
   localparam logic [11:0] THR_OV = 12'd3000;
   localparam logic [11:0] THR_UV = 12'd1000;
   localparam logic [11:0] NC     = 12'd100;
   localparam logic [11:0] NV     = 12'd2000;

   typedef struct {
      logic        det_en, uv_arm, clr, valid;
      logic [3:0]  qn;
      logic [11:0] c0, c1, c2, vb;
      logic        e_src;
      logic [3:0]  e_cause;
      logic [1:0]  e_ch;
      logic [7:0]  e_cnt;
   } vec_t;

   typedef struct {
      logic       src;
      logic [3:0] cause;
      logic [1:0] ch;
      logic [7:0] cnt;
   } exp_t;

   logic        clk_ctrl = 1'b0;
   logic        rst_ctrl_n;
   logic        det_en, uv_arm, sw_clear_fault;
   logic [11:0] thr_oc, thr_ov, thr_uv;
   logic [3:0]  qual_n;

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl[$];
   exp_t exp_q[$];

   trip_detect_if #(.DATA_W(12), .N_CH(3), .CH_W(2)) sbus ();

   trip_detect #(.DATA_W(12), .N_CH(3), .QUAL_W(4), .WD_CYCLES(1000)) dut (
      .clk_ctrl       (clk_ctrl),
      .rst_ctrl_n     (rst_ctrl_n),
      .det_en         (det_en),
      .uv_arm         (uv_arm),
      .thr_oc         (thr_oc),
      .thr_ov         (thr_ov),
      .thr_uv         (thr_uv),
      .qual_n         (qual_n),
      .sw_clear_fault (sw_clear_fault),
      .sbus           (sbus)
   );

   always #5 clk_ctrl = ~clk_ctrl;

   function automatic vec_t mk(input logic de, input logic ua, input logic cl, input logic va,
                               input logic [3:0] qn, input logic [11:0] c0, input logic [11:0] c1,
                               input logic [11:0] c2, input logic [11:0] vb, input logic es,
                               input logic [3:0] ec, input logic [1:0] ech, input logic [7:0] ecnt);
      vec_t v;
      v.det_en = de; v.uv_arm = ua; v.clr = cl; v.valid = va; v.qn = qn;
      v.c0 = c0; v.c1 = c1; v.c2 = c2; v.vb = vb;
      v.e_src = es; v.e_cause = ec; v.e_ch = ech; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic check(input exp_t e, input string tag);
      n_vec++;
      if ({sbus.trip_src, sbus.trip_cause, sbus.trip_ch, sbus.trip_count} !==
          {e.src, e.cause, e.ch, e.cnt}) begin
         n_bad++;
         $display("FAIL %s: got src=%0b cause=%b ch=%0d cnt=%0d, want src=%0b cause=%b ch=%0d cnt=%0d",
                  tag, sbus.trip_src, sbus.trip_cause, sbus.trip_ch, sbus.trip_count,
                  e.src, e.cause, e.ch, e.cnt);
      end
   endtask

   // Called just after a falling edge; outputs are checked at the next falling edge
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      det_en            = v.det_en;
      uv_arm            = v.uv_arm;
      sw_clear_fault    = v.clr;
      qual_n            = v.qn;
      sbus.sample_valid = v.valid;
      sbus.ch_mag       = {v.c2, v.c1, v.c0};
      sbus.vbus         = v.vb;
      e.src = v.e_src; e.cause = v.e_cause; e.ch = v.e_ch; e.cnt = v.e_cnt;
      exp_q.push_back(e);
      @(negedge clk_ctrl);
      e = exp_q.pop_front();
      check(e, tag);
   endtask

   initial begin
      exp_t z;
      logic [7:0] cnt;

      rst_ctrl_n = 1'b0;
      det_en = 1'b0; uv_arm = 1'b0; sw_clear_fault = 1'b0; qual_n = 4'd4;
      thr_oc = THR_OC; thr_ov = THR_OV; thr_uv = THR_UV;
      sbus.sample_valid = 1'b0; sbus.ch_mag = '0; sbus.vbus = '0;
      z.src = 1'b0; z.cause = 4'b0; z.ch = 2'd0; z.cnt = 8'd0;

      // overcurrent on ch1 with a broken run, then a full run of 4
      tbl.push_back(mk(1,0,0,0,4, NC,NC,NC,NV, 0,4'b0000,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,1,4, NC,12'd2001,NC,NV, 0,4'b0000,0,0));
      tbl.push_back(mk(1,0,0,1,4, NC,12'd1999,NC,NV, 0,4'b0000,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,1,4, NC,12'd2001,NC,NV, 0,4'b0000,0,0));
      tbl.push_back(mk(1,0,0,1,4, NC,12'd2001,NC,NV, 1,4'b0001,1,1));
      tbl.push_back(mk(1,0,0,0,4, NC,NC,NC,NV, 1,4'b0001,1,1));
      tbl.push_back(mk(1,0,1,0,4, NC,NC,NC,NV, 0,4'b0000,0,1));
      // strict compares at threshold, then single-sample overvoltage
      for (int i = 0; i < 20; i++) tbl.push_back(mk(1,0,0,1,4, THR_OC,THR_OC,THR_OC,NV, 0,4'b0000,0,1));
      tbl.push_back(mk(1,0,0,0,1, NC,NC,NC,NV, 0,4'b0000,0,1));
      tbl.push_back(mk(1,0,0,1,1, NC,NC,NC,THR_OV, 0,4'b0000,0,1));
      tbl.push_back(mk(1,0,0,1,1, NC,NC,NC,12'd3001, 1,4'b0010,0,2));
      tbl.push_back(mk(1,0,1,0,1, NC,NC,NC,NV, 0,4'b0000,0,2));
      // undervoltage ignored until armed
      for (int i = 0; i < 10; i++) tbl.push_back(mk(1,0,0,1,3, NC,NC,NC,12'd999, 0,4'b0000,0,2));
      tbl.push_back(mk(1,1,0,1,3, NC,NC,NC,THR_UV, 0,4'b0000,0,2));
      tbl.push_back(mk(1,1,0,1,3, NC,NC,NC,12'd999, 0,4'b0000,0,2));
      tbl.push_back(mk(1,1,0,1,3, NC,NC,NC,12'd999, 0,4'b0000,0,2));
      tbl.push_back(mk(1,1,0,1,3, NC,NC,NC,12'd999, 1,4'b0100,0,3));
      tbl.push_back(mk(1,0,1,0,3, NC,NC,NC,NV, 0,4'b0000,0,3));
      // simultaneous ch0, ch2 and OV; later UV must not be merged in
      tbl.push_back(mk(1,0,0,1,2, 12'd2500,NC,12'd2500,12'd3500, 0,4'b0000,0,3));
      tbl.push_back(mk(1,0,0,1,2, 12'd2500,NC,12'd2500,12'd3500, 1,4'b0011,0,4));
      tbl.push_back(mk(1,1,0,1,2, NC,NC,NC,12'd500, 1,4'b0011,0,4));
      tbl.push_back(mk(1,1,0,1,2, NC,NC,NC,12'd500, 1,4'b0011,0,4));
      // disable does not clear; clear on a qualifying strobe discards it
      tbl.push_back(mk(0,0,0,0,2, NC,NC,NC,NV, 1,4'b0011,0,4));
      tbl.push_back(mk(0,0,0,1,2, NC,NC,NC,NV, 1,4'b0011,0,4));
      tbl.push_back(mk(1,0,1,1,2, NC,NC,NC,12'd3500, 0,4'b0000,0,4));
      tbl.push_back(mk(1,0,0,1,2, NC,NC,NC,12'd3500, 0,4'b0000,0,4));
      tbl.push_back(mk(1,0,0,1,2, NC,NC,NC,12'd3500, 1,4'b0010,0,5));
      // clear while armed restarts qualification
      tbl.push_back(mk(1,0,1,0,3, NC,NC,NC,NV, 0,4'b0000,0,5));
      tbl.push_back(mk(1,0,0,1,3, 12'd2500,NC,NC,NV, 0,4'b0000,0,5));
      tbl.push_back(mk(1,0,0,1,3, 12'd2500,NC,NC,NV, 0,4'b0000,0,5));
      tbl.push_back(mk(1,0,1,0,3, NC,NC,NC,NV, 0,4'b0000,0,5));
      tbl.push_back(mk(1,0,0,1,3, 12'd2500,NC,NC,NV, 0,4'b0000,0,5));
      tbl.push_back(mk(1,0,0,1,3, 12'd2500,NC,NC,NV, 0,4'b0000,0,5));
      tbl.push_back(mk(1,0,0,1,3, 12'd2500,NC,NC,NV, 1,4'b0001,0,6));
      tbl.push_back(mk(1,0,1,0,1, NC,NC,NC,NV, 0,4'b0000,0,6));
      tbl.push_back(mk(1,0,0,1,1, NC,NC,12'd2500,NV, 1,4'b0001,2,7));
      // clear with detector off goes to IDLE, where samples are ignored
      tbl.push_back(mk(0,0,1,0,1, NC,NC,NC,NV, 0,4'b0000,0,7));
      tbl.push_back(mk(0,0,0,1,1, 12'd2500,NC,NC,12'd3500, 0,4'b0000,0,7));
      tbl.push_back(mk(0,0,0,1,1, 12'd2500,NC,NC,12'd3500, 0,4'b0000,0,7));

      repeat (2) @(negedge clk_ctrl);
      check(z, "reset");
      rst_ctrl_n = 1'b1;
      @(negedge clk_ctrl);

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // trip_count saturation, with qual_n=0 acting as 1
      cnt = 8'd7;
      apply(mk(1,0,0,0,0, NC,NC,NC,NV, 0,4'b0000,0,cnt), "sat_arm");
      for (int i = 0; i < 252; i++) begin
         if (cnt != 8'hFF) cnt = cnt + 8'd1;
         apply(mk(1,0,0,1,0, NC,NC,NC,12'd3500, 1,4'b0010,0,cnt), $sformatf("sat_trip%0d", i));
         apply(mk(1,0,1,0,0, NC,NC,NC,NV, 0,4'b0000,0,cnt), $sformatf("sat_clr%0d", i));
      end

      // sample-loss watchdog
`ifdef TRIP_WDOG_EN
      for (int i = 1; i < 1000; i++)
         apply(mk(1,0,0,0,1, NC,NC,NC,NV, 0,4'b0000,0,8'hFF), $sformatf("wd_wait%0d", i));
      apply(mk(1,0,0,0,1, NC,NC,NC,NV, 1,4'b1000,0,8'hFF), "wd_trip");
`else
      for (int i = 0; i < 5000; i++)
         apply(mk(1,0,0,0,1, NC,NC,NC,NV, 0,4'b0000,0,8'hFF), $sformatf("nowd%0d", i));
`endif

      // asynchronous reset while tripped
      apply(mk(1,0,1,0,1, NC,NC,NC,NV, 0,4'b0000,0,8'hFF), "pre_rst_clr");
      apply(mk(1,0,0,1,1, NC,NC,NC,12'd3500, 1,4'b0010,0,8'hFF), "pre_rst_trip");
      #2 rst_ctrl_n = 1'b0;
      #1 check(z, "async_rst");
      @(negedge clk_ctrl);
      rst_ctrl_n = 1'b1;
      apply(mk(0,0,0,1,1, NC,NC,NC,12'd3500, 0,4'b0000,0,0), "post_rst_idle");
      apply(mk(1,0,0,0,1, NC,NC,NC,NV, 0,4'b0000,0,0), "post_rst_arm");
      apply(mk(1,0,0,1,1, NC,NC,NC,12'd3500, 1,4'b0010,0,1), "post_rst_trip");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
